// File: rtl/button_input_handler.sv
// Synchronizes, debounces and edge-detects the five setting buttons, producing
// up/down/reset pulses and the one-hot field cursor. Define BUTTON_AUTOREPEAT_EN for up/down auto-repeat.
module button_input_handler #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_reset,
    output logic       up,
    output logic       down,
    output logic       reset,
    output logic [2:0] cursorPos
);

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_RST   = 4;

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic            POL     = (BTN_ACTIVE_LOW != 0);

    logic [4:0]      w_norm;
    logic [4:0]      r_sync1;
    logic [4:0]      r_sync2;
    logic [4:0]      r_stable;
    logic [4:0]      r_stable_d;
    logic [DB_W-1:0] r_db_cnt [5];
    logic [4:0]      w_rise;

    // Normalizing before the synchronizer lets every flop reset to 0 = released.
    assign w_norm = {btn_reset, btn_right, btn_left, btn_down, btn_up} ^ {5{POL}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1    <= w_norm;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] >= DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_d;

    logic w_ud_both;
    logic w_ud_blocked;
    logic w_up_evt;
    logic w_down_evt;
    logic w_rep_up;
    logic w_rep_down;
    logic r_ud_block;

    // Once both are held, up/down stay muted until both are released.
    assign w_ud_both    = r_stable[B_UP] & r_stable[B_DOWN];
    assign w_ud_blocked = w_ud_both | r_ud_block;
    assign w_up_evt     = w_rise[B_UP]   & ~w_ud_blocked;
    assign w_down_evt   = w_rise[B_DOWN] & ~w_ud_blocked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ud_block <= 1'b0;
        end else if (w_ud_both) begin
            r_ud_block <= 1'b1;
        end else if (!r_stable[B_UP] && !r_stable[B_DOWN]) begin
            r_ud_block <= 1'b0;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int              RP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              RP_W     = $clog2(RP_MAX + 1);
    localparam logic [RP_W-1:0] RP_DLAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_PLAST = RP_W'(REPEAT_PERIOD - 1);

    logic [RP_W-1:0] r_rep_cnt;
    logic            r_rep_active;
    logic            r_rep_first;
    logic            r_rep_dir;
    logic            w_rep_hold;
    logic            w_rep_fire;

    assign w_rep_hold = ~w_ud_blocked & (r_rep_dir ? r_stable[B_UP] : r_stable[B_DOWN]);
    assign w_rep_fire = r_rep_active & w_rep_hold &
                        (r_rep_cnt >= (r_rep_first ? RP_DLAST : RP_PLAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
            r_rep_first  <= 1'b0;
            r_rep_dir    <= 1'b0;
        end else if (w_up_evt || w_down_evt) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b1;
            r_rep_first  <= 1'b1;
            r_rep_dir    <= w_up_evt;
        end else if (!r_rep_active || !w_rep_hold) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt <= r_rep_cnt + RP_W'(1);
        end
    end

    assign w_rep_up   = w_rep_fire & r_rep_dir;
    assign w_rep_down = w_rep_fire & ~r_rep_dir;
`else
    assign w_rep_up   = 1'b0;
    assign w_rep_down = 1'b0;
`endif

    logic       r_up;
    logic       r_down;
    logic       r_reset;
    logic [2:0] r_cursor;
    logic [2:0] w_cursor_next;

    // Simultaneous left and right presses cancel out.
    always_comb begin
        w_cursor_next = r_cursor;
        if (w_rise[B_RIGHT] && !w_rise[B_LEFT]) begin
            w_cursor_next = {r_cursor[0], r_cursor[2:1]};
        end else if (w_rise[B_LEFT] && !w_rise[B_RIGHT]) begin
            w_cursor_next = {r_cursor[1:0], r_cursor[2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up     <= 1'b0;
            r_down   <= 1'b0;
            r_reset  <= 1'b0;
            r_cursor <= 3'b100;
        end else begin
            r_up     <= w_up_evt | w_rep_up;
            r_down   <= w_down_evt | w_rep_down;
            r_reset  <= w_rise[B_RST];
            r_cursor <= w_cursor_next;
        end
    end

    assign up        = r_up;
    assign down      = r_down;
    assign reset     = r_reset;
    assign cursorPos = r_cursor;

endmodule

// File: tb/tb_button_input_handler.sv
// Directed bench for button_input_handler: debounce latency, bounce rejection,
// cursor rotation, up/down conflict, optional auto-repeat and reset mid-press.
module tb_button_input_handler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_n;  // {reset, right, left, down, up}, active low
    logic       up;
    logic       down;
    logic       reset;
    logic [2:0] cursorPos;

    int n_pass  = 0;
    int n_total = 0;
    int n_up    = 0;
    int n_down  = 0;
    int n_rst   = 0;

    button_input_handler #(
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW (1),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_n[0]),
        .btn_down (btn_n[1]),
        .btn_left (btn_n[2]),
        .btn_right(btn_n[3]),
        .btn_reset(btn_n[4]),
        .up       (up),
        .down     (down),
        .reset    (reset),
        .cursorPos(cursorPos)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_up   += int'(up);
        n_down += int'(down);
        n_rst  += int'(reset);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic press(input logic [4:0] mask);
        btn_n = btn_n & ~mask;
        tick(10);
        btn_n = btn_n | mask;
        tick(10);
    endtask

    int base_u;
    int base_d;
    int base_r;
    int got_q[$];
    int exp_q[$];
    int rel_k;
    int exp_cnt;

    initial begin
        rst_n = 1'b0;
        btn_n = 5'b11111;
        tick(3);
        check("rst_up", 32'(up), 0);
        check("rst_down", 32'(down), 0);
        check("rst_reset", 32'(reset), 0);
        check("rst_cursor", 32'(cursorPos), 32'b100);
        rst_n = 1'b1;
        tick(2);

        // Clean press of up: pulse only in the cycle after edge 7
`ifdef BUTTON_AUTOREPEAT_EN
        rel_k   = 33;
        exp_cnt = 5;
        exp_q   = '{20, 25, 30, 35};
`else
        rel_k   = 43;
        exp_cnt = 1;
        exp_q   = {};
`endif
        base_u = n_up;
        base_d = n_down;
        base_r = n_rst;
        btn_n[0] = 1'b0;
        tick(6);
        check("up_before", 32'(up), 0);
        tick(1);
        check("up_pulse", 32'(up), 1);
        check("up_no_down", 32'(down), 0);
        check("up_no_reset", 32'(reset), 0);
        for (int k = 1; k <= 45; k++) begin
            tick(1);
            if (k == 1) check("up_after", 32'(up), 0);
            if (up) got_q.push_back(k);
            if (k == rel_k) btn_n[0] = 1'b1;
        end
        tick(10);
        check("up_count", 32'(n_up - base_u), 32'(exp_cnt));
        check("up_rep_num", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("up_rep_off", 32'(got_q[i]), 32'(exp_q[i]));
        check("up_side_down", 32'(n_down - base_d), 0);
        check("up_side_reset", 32'(n_rst - base_r), 0);

        // Bounce on down never reaches 4 stable cycles
        base_d = n_down;
        btn_n[1] = 1'b0; tick(3);
        btn_n[1] = 1'b1; tick(1);
        btn_n[1] = 1'b0; tick(3);
        btn_n[1] = 1'b1; tick(12);
        check("bounce_none", 32'(n_down - base_d), 0);
        btn_n[1] = 1'b0; tick(10);
        btn_n[1] = 1'b1; tick(10);
        check("bounce_then_hold", 32'(n_down - base_d), 1);

        // Cursor rotation
        check("cur_init", 32'(cursorPos), 32'b100);
        btn_n[3] = 1'b0;
        tick(6);
        check("cur_r1_early", 32'(cursorPos), 32'b100);
        tick(1);
        check("cur_r1", 32'(cursorPos), 32'b010);
        tick(3);
        btn_n[3] = 1'b1;
        tick(10);
        press(5'b01000);
        check("cur_r2", 32'(cursorPos), 32'b001);
        press(5'b01000);
        check("cur_r3_wrap", 32'(cursorPos), 32'b100);
        press(5'b00100);
        check("cur_left", 32'(cursorPos), 32'b001);
        press(5'b01100);
        check("cur_both", 32'(cursorPos), 32'b001);

        // Up held, then down pressed: down suppressed
        base_u = n_up;
        base_d = n_down;
        btn_n[0] = 1'b0; tick(10);
        btn_n[1] = 1'b0; tick(10);
        btn_n[0] = 1'b1;
        btn_n[1] = 1'b1;
        tick(10);
        check("conf_up", 32'(n_up - base_u), 1);
        check("conf_down", 32'(n_down - base_d), 0);
        base_d = n_down;
        press(5'b00010);
        check("conf_down_after", 32'(n_down - base_d), 1);

        // Reset and up pulse together
        btn_n[4] = 1'b0;
        btn_n[0] = 1'b0;
        tick(7);
        check("indep_up", 32'(up), 1);
        check("indep_reset", 32'(reset), 1);
        tick(1);
        btn_n[4] = 1'b1;
        btn_n[0] = 1'b1;
        tick(10);

        // Reset asserted mid-press with cursor at seconds
        check("mid_cur_pre", 32'(cursorPos), 32'b001);
        btn_n[4] = 1'b0;
        tick(7);
        check("mid_reset_pulse", 32'(reset), 1);
        rst_n = 1'b0;
        #1;
        check("mid_async_reset", 32'(reset), 0);
        check("mid_async_cur", 32'(cursorPos), 32'b100);
        tick(2);
        rst_n = 1'b1;
        base_r = n_rst;
        tick(6);
        check("mid_rel_early", 32'(reset), 0);
        tick(1);
        check("mid_rel_pulse", 32'(reset), 1);
        tick(1);
        check("mid_rel_after", 32'(reset), 0);
        tick(20);
        check("mid_rel_count", 32'(n_rst - base_r), 1);
        check("mid_rel_cur", 32'(cursorPos), 32'b100);
        btn_n[4] = 1'b1;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/button_input_handler.md
# button_input_handler

Front-end for the clock's setting controls, placed directly upstream of the clock state storage block. It synchronizes and debounces the five raw board push buttons and emits single-cycle up/down/reset pulses. It also maintains the 3-bit cursor that selects which time field (hours, minutes or seconds) the storage block edits. Optional auto-repeat generates a steady pulse train while up or down is held.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- `BTN_ACTIVE_LOW`, default 1: 1 means a raw button reads 0 when pressed.
- `REPEAT_DELAY`, default 50_000_000: cycles from the first pulse to the first repeat (auto-repeat only).
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent repeats (auto-repeat only).
- `clk`  in  1  100 MHz onboard clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_reset`  in  1 each  raw asynchronous buttons.
- `up`, `down`, `reset`  out  1 each  single-cycle pulses.
- `cursorPos`  out  3  one-hot field select: 3'b100 = hour, 3'b010 = minute, 3'b001 = second.

## Operation
- **Per button chain:**
  - 2-FF synchronizer.
  - Polarity normalization to "pressed = 1".
  - Debouncer: holds `stable`. A counter increments each cycle the synced level ≠ `stable`, and clears whenever they agree. When the count reaches `DEBOUNCE_CYCLES`, `stable` takes the new level and the counter clears.
- **Edges:** a rising edge of `stable` (press) is the only event source. Releases generate nothing.
- **`reset` output:** pulses for 1 cycle on a `btn_reset` press. The cursor is unaffected.
- **`up` / `down`:**
  - A press pulses the matching output for 1 cycle.
  - If both `stable_up` and `stable_down` are 1, no `up`/`down` pulses (including repeats) are emitted until both are 0 again.
  - If one of them is pressed while the other is held, the new press is suppressed.
- **Cursor:** resets to hour (3'b100).
  - A right press rotates hour→minute→second→hour.
  - A left press rotates hour→second→minute→hour.
  - If both left and right presses occur in the same cycle, the cursor is unchanged.
  - `cursorPos` is always exactly one-hot.
- **Independence:** events on different buttons in the same cycle are independent, except for the up/down and left/right pairs described above. For example, `reset` and `up` may pulse together.

## Timing
- **Reset values** while `rst_n` = 0:
  - `up` = `down` = `reset` = 0.
  - `cursorPos` = 3'b100.
  - Synchronizers and `stable` at "released".
  - All counters 0.
- **Reset mid-press:** `rst_n` asserted mid-press discards all progress. After release of reset, a still-held button must fully re-debounce and then produce exactly one press pulse.
- **Latency:** the raw level changes and stays constant from edge 0.
  - The synced level is visible after edge 2.
  - `stable` flips at edge 2+`DEBOUNCE_CYCLES`.
  - The pulse is high during the cycle after edge 3+`DEBOUNCE_CYCLES`, for exactly 1 cycle.
  - A cursor change becomes visible on the same edge as the pulse would.
- **Bounce:** any bounce that returns to `stable` before the count completes restarts debouncing. A glitch shorter than `DEBOUNCE_CYCLES` produces no pulse.
- **Counter widths:** `$clog2(param+1)`. Counters saturate and never wrap.

## Configuration
- **`BUTTON_AUTOREPEAT_EN` defined:** while exactly one of up/down is `stable` = 1 and unblocked:
  - A repeat counter starts at the initial pulse.
  - A repeat pulse is emitted `REPEAT_DELAY` cycles after the initial pulse, then every `REPEAT_PERIOD` cycles.
  - Release, blocking by both-pressed, or reset clears the repeat counter immediately, and no further repeats occur.
- **`BUTTON_AUTOREPEAT_EN` undefined:** no repeat logic is synthesized. Exactly one pulse is emitted per press, regardless of hold time.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5, `BTN_ACTIVE_LOW`=1.
- **Clean press:** drive `btn_up` low at edge 0 and hold for 50 cycles → `up` high only in the cycle after edge 7. `down` and `reset` stay 0. Hold the button without auto-repeat → no further pulses.
- **Bounce:** toggle `btn_down` low for 3 cycles, high for 1, low for 3, then high → no `down` pulse. Then hold low for 10 cycles → exactly one `down` pulse.
- **Cursor wrap:** 3 right presses from reset → `cursorPos` goes 100→010→001→100. Then 1 left press → 001. Simultaneous left+right press → unchanged.
- **Up+down conflict:** press up and hold, then press down → 1 `up` pulse and no `down` pulse. Release both, then press down → 1 `down` pulse.
- **Auto-repeat (macro defined):** hold up for 40 cycles after the first pulse → pulses at offsets 0, 20, 25, 30, 35 from the first pulse. Release → none further.
- **Reset mid-operation:** assert `rst_n`=0 for 2 cycles while `btn_reset` is held and cursor = 001 → outputs go to reset values at once. After release, exactly one `reset` pulse appears 7 edges later and `cursorPos` = 100.
